fg_sram_fetch: RTL and testbench
================================

# fg_sram_fetch

Foreground SRAM fetch stage. It sits directly upstream of the compositing pipeline and serves that pipeline's per-pixel foreground requests (signed x/y plus an active flag). Every accepted request slot gets exactly one response 3 cycles later, either pixel data or a skip, which meets the pipeline's fixed fetch-latency contract. It also arbitrates the single SRAM port between these reads and buffered foreground frame writes from the capture side.

## Interface
- R_WIDTH, 5, red bits
- G_WIDTH, 6, green bits
- B_WIDTH, 5, blue bits
- PIXEL_SIZE, R_WIDTH+G_WIDTH+B_WIDTH (local), pixel word width
- PRECISION, 11, coordinate width
- RESOLUTION_X, 800, foreground width in pixels
- RESOLUTION_Y, 600, foreground height in pixels
- ADDR_WIDTH, 19, SRAM word-address width
- WFIFO_DEPTH, 4, write FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  synchronous, active-low reset
- slot_valid  in  1  request slot present this cycle (tied to the pipeline's bg_pixel_ready)
- req_active  in  1  foreground wanted for this slot
- req_x  in  PRECISION+1  signed foreground x
- req_y  in  PRECISION+1  signed foreground y
- fg_pixel_out  out  PIXEL_SIZE  fetched pixel (registered)
- fg_pixel_skip  out  1  no valid foreground for this response
- fg_pixel_ready  out  1  response present
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_x  in  PRECISION  write x, unsigned
- wr_y  in  PRECISION  write y, unsigned
- wr_data  in  PIXEL_SIZE  write pixel
- sram_addr  out  ADDR_WIDTH  SRAM address (registered)
- sram_oe_n  out  1  SRAM output enable, active-low
- sram_we_n  out  1  SRAM write enable, active-low
- sram_data_oe  out  1  drive the data bus
- sram_data_out  out  PIXEL_SIZE  write data
- sram_data_in  in  PIXEL_SIZE  read data, valid one cycle after the address

## Operation
- Address: `addr = y*RESOLUTION_X + x`, computed at ADDR_WIDTH bits. No multiplier is required; shift-add is fine.
- A read is issued only when `slot_valid && req_active` and the coordinate is in range: 0 ≤ x < RESOLUTION_X and 0 ≤ y < RESOLUTION_Y, with the signed compare done at PRECISION+1 bits. Negative coordinates count as out of range.
- Skip cases: `slot_valid && (!req_active || out of range)`.
  - The response is `fg_pixel_skip=1`, `fg_pixel_out=0`.
  - No SRAM access is made.
- `slot_valid=0`: no response is produced.
- Read pipeline has three stages, each with a valid bit and a skip bit:
  - S1: address register.
  - S2: SRAM drive. `sram_addr` is driven and `sram_oe_n=0`.
  - S3: capture `sram_data_in` into the output register.
- Port arbitration:
  - A read in S1 owns the SRAM port in the following cycle.
  - A write drains from the FIFO head only in cycles where no read owns the port: `sram_we_n=0`, `sram_data_oe=1`, and the address is computed from wr_x/wr_y.
  - Reads always win. Writes may starve during active video; blanking slots drain them.
- Writes with out-of-range coordinates are accepted and then discarded. No SRAM cycle is issued for them.
- `wr_ready = !fifo_full`. A simultaneous push and pop while full is not allowed; `wr_ready` stays 0 when full.
- There is no read-after-write forwarding. A read that coincides with a pending write to the same address returns the old SRAM contents.

## Timing
- Response latency is fixed: for a slot sampled at edge N, `fg_pixel_ready` is high for exactly one cycle, after edge N+3.
- Back-to-back slots give back-to-back responses, with no bubbles and no reordering.
- SRAM read: address and `oe_n` are registered out after edge N+1, and data is sampled at edge N+2.
- A write occupies the port for one cycle. A write and a read are never driven in the same cycle.
- Reset values (applied at the first edge with rst_n low):
  - `fg_pixel_ready=0`, `fg_pixel_skip=0`, `fg_pixel_out=0`
  - `sram_addr=0`, `sram_oe_n=1`, `sram_we_n=1`, `sram_data_oe=0`, `sram_data_out=0`
  - `wr_ready=0`
- The cycle after rst_n rises, `wr_ready=1`.
- Reset mid-operation:
  - All in-flight reads are dropped, and no `fg_pixel_ready` is emitted for slots sampled before reset.
  - The FIFO is emptied and any pending writes are lost.

## Configuration
- `FG_FETCH_WRITE_FIFO_EN` defined: the write path uses a WFIFO_DEPTH-entry FIFO as described above.
- Undefined: the write path uses a single holding register, and `wr_ready` is high only while that register is empty. Read behaviour is identical in both cases.

## Test plan
- Write (10,2) data 16'hABCD, idle 2 cycles, then read slot (10,2) active at edge N. Required: at N+3, `fg_pixel_ready=1`, `skip=0`, `out=16'hABCD`, and the read cycle showed `sram_addr=1610`.
- Slots at (-1,0), (800,5), (0,600), and (3,3) with `req_active=0`. Required: four skip responses at N+3..N+6, with `sram_oe_n` held at 1 throughout.
- 800 consecutive active slots on row 7 with `slot_valid` held high. Required: 800 consecutive ready cycles, addresses 5600..6399 in order, no gaps.
- With reads continuous, push 4 writes. Required: `wr_ready` drops after the 4th push, no write is issued, and all 4 writes drain within 4 cycles once `slot_valid` drops.
- Assert rst_n low one cycle after two active slots. Required: no `fg_pixel_ready` afterwards, `sram_oe_n=1`, `wr_ready=0` during reset and 1 after.
- Build without `FG_FETCH_WRITE_FIFO_EN`. Required: the second back-to-back write sees `wr_ready=0` until the first has been written.

Source files
------------

// File: rtl/fg_sram_fetch.sv
`timescale 1ns/1ps
// fg_sram_fetch: answers per-pixel foreground slots from SRAM and drains buffered frame writes into idle port cycles.
// Latency: fixed 3 cycles from slot to response (S1 address, S2 SRAM drive, S3 capture, registered output).
// Backpressure: none on reads (every slot is answered); writes stall on wr_ready while the write buffer is full.
// Build option: FG_FETCH_WRITE_FIFO_EN selects a WFIFO_DEPTH-entry write FIFO instead of one holding register.
module fg_sram_fetch #(
    parameter int R_WIDTH      = 5,
    parameter int G_WIDTH      = 6,
    parameter int B_WIDTH      = 5,
    parameter int PRECISION    = 11,
    parameter int RESOLUTION_X = 800,
    parameter int RESOLUTION_Y = 600,
    parameter int ADDR_WIDTH   = 19,
    parameter int WFIFO_DEPTH  = 4,
    localparam int PIXEL_SIZE  = R_WIDTH + G_WIDTH + B_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  slot_valid,
    input  logic                  req_active,
    input  logic [PRECISION:0]    req_x,
    input  logic [PRECISION:0]    req_y,
    output logic [PIXEL_SIZE-1:0] fg_pixel_out,
    output logic                  fg_pixel_skip,
    output logic                  fg_pixel_ready,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [PRECISION-1:0]  wr_x,
    input  logic [PRECISION-1:0]  wr_y,
    input  logic [PIXEL_SIZE-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  sram_data_oe,
    output logic [PIXEL_SIZE-1:0] sram_data_out,
    input  logic [PIXEL_SIZE-1:0] sram_data_in
);
    localparam int CW = PRECISION + 1;
    localparam int WE = ADDR_WIDTH + PIXEL_SIZE;

    if (WFIFO_DEPTH < 2 || (WFIFO_DEPTH & (WFIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("WFIFO_DEPTH must be a power of two and at least 2");
    end

    // Row-major word address; the constant multiply reduces to shift-add.
    function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [PRECISION-1:0] x,
                                                      input logic [PRECISION-1:0] y);
        return ADDR_WIDTH'(y) * ADDR_WIDTH'(RESOLUTION_X) + ADDR_WIDTH'(x);
    endfunction

    logic                  s1_vld_q, s1_vld_d, s1_skip_q, s1_skip_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic                  s2_vld_q, s2_vld_d, s2_skip_q, s2_skip_d;
    logic                  s3_vld_q, s3_vld_d, s3_skip_q, s3_skip_d;
    logic [PIXEL_SIZE-1:0] s3_dat_q, s3_dat_d;
    logic                  out_rdy_q, out_rdy_d, out_skip_q, out_skip_d;
    logic [PIXEL_SIZE-1:0] out_dat_q, out_dat_d;
    logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic                  sram_oe_n_q, sram_oe_n_d, sram_we_n_q, sram_we_n_d;
    logic                  sram_data_oe_q, sram_data_oe_d;
    logic [PIXEL_SIZE-1:0] sram_data_out_q, sram_data_out_d;
    logic                  rdy_en_q, rdy_en_d;

    logic          rd_x_ok, rd_y_ok, rd_hit, rd_own;
    logic          wr_in_range, wq_push, wq_pop, wq_full, wq_empty;
    logic [WE-1:0] wq_wdat, wq_head;

    // Negative coordinates have the sign bit set, so an unsigned compare on the rest is enough.
    assign rd_x_ok = !req_x[CW-1] && (req_x < CW'(RESOLUTION_X));
    assign rd_y_ok = !req_y[CW-1] && (req_y < CW'(RESOLUTION_Y));
    assign rd_hit  = slot_valid && req_active && rd_x_ok && rd_y_ok;
    assign rd_own  = s1_vld_q && !s1_skip_q;

    // Out-of-range writes are accepted but never enter the buffer.
    assign wr_in_range = (wr_x < PRECISION'(RESOLUTION_X)) && (wr_y < PRECISION'(RESOLUTION_Y));
    assign wr_ready    = rdy_en_q && !wq_full;
    assign wq_push     = wr_valid && wr_ready && wr_in_range;
    assign wq_pop      = !rd_own && !wq_empty;
    assign wq_wdat     = {pix_addr(wr_x, wr_y), wr_data};

`ifdef FG_FETCH_WRITE_FIFO_EN
    localparam int PW = $clog2(WFIFO_DEPTH);
    logic [WE-1:0] wq_mem [WFIFO_DEPTH];
    logic [PW-1:0] wq_wptr_q, wq_wptr_d, wq_rptr_q, wq_rptr_d;
    logic [PW:0]   wq_cnt_q, wq_cnt_d;

    assign wq_full  = (wq_cnt_q == (PW + 1)'(WFIFO_DEPTH));
    assign wq_empty = (wq_cnt_q == '0);
    assign wq_head  = wq_mem[wq_rptr_q];

    // Pointers wrap naturally because the depth is a power of two.
    always_comb begin
        wq_wptr_d = wq_wptr_q + PW'(wq_push);
        wq_rptr_d = wq_rptr_q + PW'(wq_pop);
        wq_cnt_d  = wq_cnt_q + (PW + 1)'(wq_push) - (PW + 1)'(wq_pop);
    end

    // Storage needs no reset; occupancy is tracked by the count.
    always_ff @(posedge clk) begin
        if (wq_push) wq_mem[wq_wptr_q] <= wq_wdat;
    end

    // FIFO pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wq_wptr_q <= '0;
            wq_rptr_q <= '0;
            wq_cnt_q  <= '0;
        end else begin
            wq_wptr_q <= wq_wptr_d;
            wq_rptr_q <= wq_rptr_d;
            wq_cnt_q  <= wq_cnt_d;
        end
    end
`else
    logic          hold_vld_q, hold_vld_d;
    logic [WE-1:0] hold_ent_q, hold_ent_d;

    assign wq_full  = hold_vld_q;
    assign wq_empty = !hold_vld_q;
    assign wq_head  = hold_ent_q;

    // Push only happens while empty and pop only while full, so they never collide.
    always_comb begin
        hold_vld_d = hold_vld_q;
        hold_ent_d = hold_ent_q;
        if (wq_push) begin
            hold_vld_d = 1'b1;
            hold_ent_d = wq_wdat;
        end else if (wq_pop) begin
            hold_vld_d = 1'b0;
        end
    end

    // Holding register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_vld_q <= 1'b0;
            hold_ent_q <= '0;
        end else begin
            hold_vld_q <= hold_vld_d;
            hold_ent_q <= hold_ent_d;
        end
    end
`endif

    // Read pipeline advance and SRAM port arbitration: a read in S1 always takes the port next cycle.
    always_comb begin
        s1_vld_d        = slot_valid;
        s1_skip_d       = !rd_hit;
        s1_addr_d       = pix_addr(req_x[PRECISION-1:0], req_y[PRECISION-1:0]);
        s2_vld_d        = s1_vld_q;
        s2_skip_d       = s1_skip_q;
        s3_vld_d        = s2_vld_q;
        s3_skip_d       = s2_skip_q;
        s3_dat_d        = (s2_vld_q && !s2_skip_q) ? sram_data_in : '0;
        out_rdy_d       = s3_vld_q;
        out_skip_d      = s3_vld_q && s3_skip_q;
        out_dat_d       = s3_vld_q ? s3_dat_q : '0;
        sram_addr_d     = sram_addr_q;
        sram_oe_n_d     = 1'b1;
        sram_we_n_d     = 1'b1;
        sram_data_oe_d  = 1'b0;
        sram_data_out_d = sram_data_out_q;
        rdy_en_d        = 1'b1;
        if (rd_own) begin
            sram_addr_d = s1_addr_q;
            sram_oe_n_d = 1'b0;
        end else if (wq_pop) begin
            sram_addr_d     = wq_head[WE-1:PIXEL_SIZE];
            sram_data_out_d = wq_head[PIXEL_SIZE-1:0];
            sram_we_n_d     = 1'b0;
            sram_data_oe_d  = 1'b1;
        end
    end

    // State registers; reset drops every in-flight read and idles the port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q        <= 1'b0;
            s1_skip_q       <= 1'b0;
            s1_addr_q       <= '0;
            s2_vld_q        <= 1'b0;
            s2_skip_q       <= 1'b0;
            s3_vld_q        <= 1'b0;
            s3_skip_q       <= 1'b0;
            s3_dat_q        <= '0;
            out_rdy_q       <= 1'b0;
            out_skip_q      <= 1'b0;
            out_dat_q       <= '0;
            sram_addr_q     <= '0;
            sram_oe_n_q     <= 1'b1;
            sram_we_n_q     <= 1'b1;
            sram_data_oe_q  <= 1'b0;
            sram_data_out_q <= '0;
            rdy_en_q        <= 1'b0;
        end else begin
            s1_vld_q        <= s1_vld_d;
            s1_skip_q       <= s1_skip_d;
            s1_addr_q       <= s1_addr_d;
            s2_vld_q        <= s2_vld_d;
            s2_skip_q       <= s2_skip_d;
            s3_vld_q        <= s3_vld_d;
            s3_skip_q       <= s3_skip_d;
            s3_dat_q        <= s3_dat_d;
            out_rdy_q       <= out_rdy_d;
            out_skip_q      <= out_skip_d;
            out_dat_q       <= out_dat_d;
            sram_addr_q     <= sram_addr_d;
            sram_oe_n_q     <= sram_oe_n_d;
            sram_we_n_q     <= sram_we_n_d;
            sram_data_oe_q  <= sram_data_oe_d;
            sram_data_out_q <= sram_data_out_d;
            rdy_en_q        <= rdy_en_d;
        end
    end

    assign fg_pixel_ready = out_rdy_q;
    assign fg_pixel_skip  = out_skip_q;
    assign fg_pixel_out   = out_dat_q;
    assign sram_addr      = sram_addr_q;
    assign sram_oe_n      = sram_oe_n_q;
    assign sram_we_n      = sram_we_n_q;
    assign sram_data_oe   = sram_data_oe_q;
    assign sram_data_out  = sram_data_out_q;
endmodule

// File: tb/tb_fg_sram_fetch.sv
`timescale 1ns/1ps
// tb_fg_sram_fetch: randomized and directed slots/writes against a coordinate-level reference model.
// Expected responses, SRAM reads and SRAM writes are queued at stimulus time and popped by negedge monitors.
// An SRAM behavioural model answers reads combinationally from the driven address.
module tb_fg_sram_fetch;
    localparam int AW = 19;
    localparam int RX = 800;
    localparam int RY = 600;
`ifdef FG_FETCH_WRITE_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n, slot_valid, req_active, wr_valid;
    logic [11:0] req_x, req_y;
    logic [10:0] wr_x, wr_y;
    logic [15:0] wr_data;
    logic [15:0] fg_pixel_out, sram_data_out, sram_data_in;
    logic        fg_pixel_skip, fg_pixel_ready, wr_ready;
    logic [18:0] sram_addr;
    logic        sram_oe_n, sram_we_n, sram_data_oe;

    always #5 clk = ~clk;

    fg_sram_fetch dut (
        .clk(clk), .rst_n(rst_n), .slot_valid(slot_valid), .req_active(req_active),
        .req_x(req_x), .req_y(req_y), .fg_pixel_out(fg_pixel_out), .fg_pixel_skip(fg_pixel_skip),
        .fg_pixel_ready(fg_pixel_ready), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x),
        .wr_y(wr_y), .wr_data(wr_data), .sram_addr(sram_addr), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_data_oe(sram_data_oe), .sram_data_out(sram_data_out),
        .sram_data_in(sram_data_in)
    );

    // SRAM behavioural model
    logic [15:0] sram_mem [0:(1<<AW)-1];
    assign sram_data_in = !sram_oe_n ? sram_mem[sram_addr] : 16'hDEAD;
    always @(posedge clk) if (!sram_we_n && sram_data_oe) sram_mem[sram_addr] <= sram_data_out;

    function automatic logic [15:0] init_pat(input int a);
        return 16'((a * 37) ^ 32'h5A5A ^ (a >> 7));
    endfunction

    // Reference memory: committed writes overlay the initial pattern.
    logic [15:0] ref_wr [int];
    function automatic logic [15:0] ref_rd(input int a);
        return ref_wr.exists(a) ? ref_wr[a] : init_pat(a);
    endfunction

    typedef struct { logic skip; logic [15:0] dat; int cyc; } resp_t;
    typedef struct { int a; logic [15:0] d; } wr_t;
    resp_t exp_q[$];
    int    addr_q[$];
    wr_t   wexp_q[$];
    int    wcoords[$];

    int n_tests = 0, n_fail = 0, cyc = 0, n_rd = 0, n_wr = 0, n_resp = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got an event required none (cycle %0d)", name, cyc);
    endtask

    // Monitors: responses, SRAM reads and SRAM writes.
    always @(negedge clk) begin
        resp_t e;
        wr_t   w;
        if (fg_pixel_ready === 1'b1) begin
            n_resp++;
            if (exp_q.size() == 0) fail_now("unexpected_ready");
            else begin
                e = exp_q.pop_front();
                chk("resp_cycle", cyc, e.cyc);
                chk("resp_skip", 32'(fg_pixel_skip), 32'(e.skip));
                chk("resp_data", 32'(fg_pixel_out), 32'(e.dat));
            end
        end
        if (sram_oe_n === 1'b0) begin
            n_rd++;
            chk("rd_excl", {30'd0, sram_we_n, sram_data_oe}, 32'd2);
            if (addr_q.size() == 0) fail_now("unexpected_read");
            else chk("rd_addr", 32'(sram_addr), 32'(addr_q.pop_front()));
        end
        if (sram_we_n === 1'b0) begin
            n_wr++;
            chk("wr_data_oe", 32'(sram_data_oe), 32'd1);
            if (wexp_q.size() == 0) fail_now("unexpected_write");
            else begin
                w = wexp_q.pop_front();
                chk("wr_addr", 32'(sram_addr), 32'(w.a));
                chk("wr_data", 32'(sram_data_out), 32'(w.d));
                ref_wr[w.a] = w.d;
            end
        end
    end

    // One clock: capture the applied inputs, let the edge happen, update the model.
    task automatic step();
        logic sv, act, wacc, rst;
        int   xi, yi, a;
        logic [10:0] wx, wy;
        logic [15:0] wd;
        resp_t r;
        wr_t   w;
        @(negedge clk);
        rst = rst_n; sv = slot_valid; act = req_active;
        xi = int'($signed(req_x)); yi = int'($signed(req_y));
        wacc = wr_valid && wr_ready; wx = wr_x; wy = wr_y; wd = wr_data;
        @(posedge clk);
        #1;
        if (!rst) begin
            exp_q.delete(); addr_q.delete(); wexp_q.delete();
        end else begin
            if (sv) begin
                r.cyc = cyc + 3;
                if (act && xi >= 0 && xi < RX && yi >= 0 && yi < RY) begin
                    a = yi * RX + xi;
                    r.skip = 1'b0; r.dat = ref_rd(a);
                    addr_q.push_back(a);
                end else begin
                    r.skip = 1'b1; r.dat = 16'h0;
                end
                exp_q.push_back(r);
            end
            if (wacc && int'(wx) < RX && int'(wy) < RY) begin
                w.a = int'(wy) * RX + int'(wx); w.d = wd;
                wexp_q.push_back(w);
                wcoords.push_back(w.a);
            end
        end
    endtask

    task automatic set_slot(input logic v, input logic a, input int x, input int y);
        slot_valid = v; req_active = a; req_x = 12'(x); req_y = 12'(y);
    endtask

    task automatic set_wr(input logic v, input int x, input int y, input logic [15:0] d);
        wr_valid = v; wr_x = 11'(x); wr_y = 11'(y); wr_data = d;
    endtask

    task automatic idle(input int n);
        set_slot(0, 0, 0, 0);
        set_wr(0, 0, 0, 16'h0);
        repeat (n) step();
    endtask

    initial begin
        int r0, rd0, w0;
        for (int i = 0; i < (1 << AW); i++) sram_mem[i] = init_pat(i);
        rst_n = 1'b0;
        set_slot(0, 0, 0, 0);
        set_wr(0, 0, 0, 16'h0);
        step(); step();
        chk("rst_ready", 32'(fg_pixel_ready), 0);
        chk("rst_skip", 32'(fg_pixel_skip), 0);
        chk("rst_out", 32'(fg_pixel_out), 0);
        chk("rst_addr", 32'(sram_addr), 0);
        chk("rst_oe_n", 32'(sram_oe_n), 1);
        chk("rst_we_n", 32'(sram_we_n), 1);
        chk("rst_data_oe", 32'(sram_data_oe), 0);
        chk("rst_data_out", 32'(sram_data_out), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        rst_n = 1'b1;
        step();
        chk("wr_ready_after_rst", 32'(wr_ready), 1);

        // Write then read the same pixel.
        set_wr(1, 10, 2, 16'hABCD); step();
        idle(2);
        set_slot(1, 1, 10, 2); step();
        idle(5);

        // Skip cases never touch the SRAM.
        rd0 = n_rd; r0 = n_resp;
        set_slot(1, 1, -1, 0);  step();
        set_slot(1, 1, 800, 5); step();
        set_slot(1, 1, 0, 600); step();
        set_slot(1, 0, 3, 3);   step();
        idle(5);
        chk("skip_no_read", n_rd - rd0, 0);
        chk("skip_resp_count", n_resp - r0, 4);

        // Full row streamed back to back.
        rd0 = n_rd; r0 = n_resp;
        for (int x = 0; x < RX; x++) begin set_slot(1, 1, x, 7); step(); end
        idle(5);
        chk("row_resp_count", n_resp - r0, RX);
        chk("row_read_count", n_rd - rd0, RX);

        // Writes starve under continuous reads, then drain once slots stop.
        w0 = n_wr;
        for (int i = 0; i < CAP; i++) begin
            chk("wr_ready_fill", 32'(wr_ready), 1);
            set_slot(1, 1, $urandom_range(0, RX - 1), 100);
            set_wr(1, i * 3, 300, 16'($urandom));
            step();
        end
        chk("wr_ready_full", 32'(wr_ready), 0);
        repeat (3) begin
            set_slot(1, 1, $urandom_range(0, RX - 1), 100);
            set_wr(1, 77, 300, 16'($urandom));
            step();
        end
        chk("wr_starved", n_wr - w0, 0);
        chk("wr_ready_starved", 32'(wr_ready), 0);
        idle(1);
        repeat (CAP) step();
        @(negedge clk); #1;
        chk("wr_drained", n_wr - w0, CAP);
        chk("wr_ready_drained", 32'(wr_ready), 1);
        @(posedge clk); #1;
        idle(4);

        // Back-to-back writes with idle reads.
        set_wr(1, 5, 310, 16'h1357); step();
        chk("wr_ready_second", 32'(wr_ready), (CAP > 1) ? 32'd1 : 32'd0);
        set_wr(1, 6, 310, 16'h2468); step();
        chk("wr_ready_after_drain", 32'(wr_ready), 1);
        if (CAP == 1) step();
        idle(3);
        set_slot(1, 1, 5, 310); step();
        set_slot(1, 1, 6, 310); step();
        idle(5);

        // Random mix: reads in rows below 400, writes in rows 400 and up.
        wcoords.delete();
        for (int i = 0; i < 600; i++) begin
            int x, y;
            x = ($urandom % 8 == 0) ? int'($signed(12'($urandom))) : $urandom_range(0, 859) - 30;
            y = ($urandom % 8 == 0) ? 600 + $urandom_range(0, 19) : $urandom_range(0, 429) - 30;
            set_slot(($urandom % 4) != 0, ($urandom % 5) != 0, x, y);
            set_wr(($urandom % 3) == 0, $urandom_range(0, 849),
                   ($urandom % 6 == 0) ? $urandom_range(600, 700) : $urandom_range(400, 599),
                   16'($urandom));
            step();
        end
        idle(10);
        foreach (wcoords[i]) begin
            set_slot(1, 1, wcoords[i] % RX, wcoords[i] / RX);
            step();
        end
        idle(6);

        // Reset mid-operation drops reads and the pending write.
        r0 = n_resp; w0 = n_wr;
        set_slot(1, 1, 20, 50); set_wr(1, 21, 50, 16'h1234); step();
        set_wr(0, 0, 0, 16'h0); set_slot(1, 1, 22, 50); step();
        set_slot(0, 0, 0, 0); rst_n = 1'b0; step();
        chk("midrst_oe_n", 32'(sram_oe_n), 1);
        chk("midrst_wr_ready", 32'(wr_ready), 0);
        chk("midrst_ready", 32'(fg_pixel_ready), 0);
        step();
        rst_n = 1'b1; step();
        chk("midrst_wr_ready_after", 32'(wr_ready), 1);
        idle(6);
        chk("midrst_no_resp", n_resp - r0, 0);
        chk("midrst_no_write", n_wr - w0, 0);
        set_slot(1, 1, 21, 50); step();
        idle(8);

        chk("left_responses", exp_q.size(), 0);
        chk("left_reads", addr_q.size(), 0);
        chk("left_writes", wexp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
